divisor_arbiter: RTL and testbench
==================================

# divisor_arbiter

Shares one `divisor_top` instance between `NREQ` requesters. Accepts divide requests, arbitrates round-robin, and sequences the divider through START/DONE. It returns the quotient and remainder to the winning requester as a one-cycle tagged response. It sits between the requesting blocks and the divider's START/NUMERADOR/DENOMINADOR/COC/RES/DONE port set.

## Interface
- `SIZE`, 32, operand/result width (must match divider `tamanyo`)
- `NREQ`, 4, number of requesters (2..8); `IDW = $clog2(NREQ)`

Ports:
- `CLK`  in  1  clock; single clock domain
- `RST_N`  in  1  reset, asynchronous, active-low; also drives the divider's reset
- `REQ`  in  NREQ  request level per requester
- `NUM_IN`  in  NREQ*SIZE  numerators; requester i at `[i*SIZE +: SIZE]`
- `DEN_IN`  in  NREQ*SIZE  denominators, same packing
- `GNT`  out  NREQ  one-hot, one-cycle accept pulse
- `DIV_START`  out  1  one-cycle start to divider
- `DIV_NUM`, `DIV_DEN`  out  SIZE  registered operands to divider
- `DIV_DONE`  in  1  divider done
- `DIV_COC`, `DIV_RES`  in  SIZE  divider quotient/remainder
- `RSP_VALID`  out  NREQ  one-hot, one-cycle response pulse
- `RSP_ID`  out  IDW  index of responding requester
- `RSP_COC`, `RSP_RES`  out  SIZE  result, held until next response
- `RSP_ERR`  out  1  divide-by-zero flag, qualified by RSP_VALID

## Operation
- FSM states are IDLE, LAUNCH, WAIT, RESP. Reset state is IDLE. Round-robin pointer `ptr` resets to 0.
- IDLE, when any REQ is high:
  - winner = first set bit at or after `ptr`, wrapping modulo NREQ
  - assert `GNT[winner]`
  - register the winner's operands into DIV_NUM/DIV_DEN and winner into RSP_ID
  - set `ptr = (winner+1) mod NREQ`
  - go to LAUNCH
- IDLE, no REQ: stay.
- LAUNCH: DIV_START=1 for exactly one cycle, then go to WAIT.
- WAIT: on the first cycle DIV_DONE=1, capture DIV_COC/DIV_RES into RSP_COC/RSP_RES, clear RSP_ERR, go to RESP. Otherwise stay; there is no timeout.
- RESP: `RSP_VALID[RSP_ID]=1` for one cycle, then go to IDLE.
- DIV_DONE is ignored outside WAIT, including a DONE still high from the previous operation during LAUNCH.
- Requester protocol:
  - hold REQ and operands stable until its GNT is seen
  - may drop REQ or reassert for a new operation from the cycle after GNT
  - REQ dropped before GNT is a legal withdrawal
- REQ changes while the arbiter is not in IDLE have no effect. Only one operation is in flight.
- Reset values: GNT, RSP_VALID, DIV_START = 0; DIV_NUM, DIV_DEN, RSP_COC, RSP_RES = 0; RSP_ID = 0; RSP_ERR = 0.
- Reset mid-operation: everything returns to reset values immediately, no response is issued, and the in-flight request is lost.

## Timing
- GNT in cycle t, when IDLE and REQ are sampled.
- DIV_START in cycle t+1.
- Divider asserts DONE at t+1+L.
- RSP_VALID at t+2+L.
- Next GNT no earlier than t+3+L. Throughput is one operation per L+3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DIV_ZERO_BYPASS_EN` defined:
  - in IDLE, a winner with DEN=0 still gets GNT and a ptr update
  - the FSM then goes directly to RESP without DIV_START
  - RSP_COC = all ones, RSP_RES = numerator, RSP_ERR = 1
  - latency is GNT at t, RSP_VALID at t+1
- Not defined: zero denominators go to the divider like any other operand, and RSP_ERR is tied to 0.

## Test plan
- Single request: requester 2 issues 100/7 → GNT[2] at t, DIV_START at t+1, then RSP_VALID[2] with RSP_ID=2, COC=14, RES=2.
- Fairness: all four REQ held high continuously → grant order 0,1,2,3,0. No GNT until the previous RSP_VALID, and each GNT is at least L+3 cycles after the previous one.
- Late request ignored: requester 1 raises REQ while requester 0 is in WAIT → no GNT[1] until the cycle after RSP_VALID[0]. Then GNT[1] is issued and requester 1's result is correct.
- Stale DONE: divider DONE held high from the prior operation into LAUNCH → not captured. The response carries the new operation's result.
- Reset in WAIT: pulse RST_N low → all outputs 0 and ptr=0, no RSP_VALID. Afterwards REQ=0b1000 gets GNT[3].
- Zero divide: 55/0 with `DIV_ZERO_BYPASS_EN` → no DIV_START; RSP_VALID one cycle after GNT with COC=0xFFFFFFFF, RES=55, ERR=1. Without the macro, DIV_START is issued and ERR=0.

Source files
------------

// File: rtl/divisor_arbiter.sv
// rtl/divisor_arbiter.sv - round-robin sharing of one divider among NREQ requesters
// Optional feature macro: DIV_ZERO_BYPASS_EN (zero denominators answered without the divider)
module divisor_arbiter #(
   parameter int SIZE = 32,
   parameter int NREQ = 4,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [NREQ-1:0]      REQ,
   input  logic [NREQ*SIZE-1:0] NUM_IN,
   input  logic [NREQ*SIZE-1:0] DEN_IN,
   output logic [NREQ-1:0]      GNT,
   output logic                 DIV_START,
   output logic [SIZE-1:0]      DIV_NUM,
   output logic [SIZE-1:0]      DIV_DEN,
   input  logic                 DIV_DONE,
   input  logic [SIZE-1:0]      DIV_COC,
   input  logic [SIZE-1:0]      DIV_RES,
   output logic [NREQ-1:0]      RSP_VALID,
   output logic [IDW-1:0]       RSP_ID,
   output logic [SIZE-1:0]      RSP_COC,
   output logic [SIZE-1:0]      RSP_RES,
   output logic                 RSP_ERR
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]        state;
   logic [IDW-1:0]    ptr;

   logic [2*NREQ-1:0] req_rot;
   logic              win_found;
   logic [IDW-1:0]    win_off;
   logic [IDW-1:0]    win_idx;
   logic [IDW-1:0]    ptr_nxt;
   logic [SIZE-1:0]   win_num;
   logic [SIZE-1:0]   win_den;
   int                win_sum;

   function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
      logic [NREQ-1:0] v;
      v = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (k == int'(idx)) v[k] = 1'b1;
      end
      return v;
   endfunction

   // Rotate requests so bit 0 is the requester at ptr; first set bit is the winner offset.
   always_comb begin
      req_rot   = {REQ, REQ} >> ptr;
      win_found = 1'b0;
      win_off   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_found && req_rot[k]) begin
            win_found = 1'b1;
            win_off   = IDW'(k);
         end
      end
      win_sum = int'(ptr) + int'(win_off);
      if (win_sum >= NREQ) win_sum = win_sum - NREQ;
      win_idx = IDW'(win_sum);
      if (int'(win_idx) == NREQ - 1) ptr_nxt = '0;
      else                           ptr_nxt = win_idx + 1'b1;
      win_num = '0;
      win_den = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (k == int'(win_idx)) begin
            win_num = NUM_IN[k*SIZE +: SIZE];
            win_den = DEN_IN[k*SIZE +: SIZE];
         end
      end
   end

`ifdef DIV_ZERO_BYPASS_EN
   logic rsp_err_q;
   logic bypass;
   assign RSP_ERR = rsp_err_q;
`else
   assign RSP_ERR = 1'b0;
`endif

   // State names mark the cycle in which each registered output is visible:
   // LAUNCH carries GNT, the first WAIT cycle carries DIV_START, RESP carries RSP_VALID.
   // RESP re-arbitrates so back-to-back operations run every L+3 cycles.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= S_IDLE;
         ptr       <= '0;
         GNT       <= '0;
         DIV_START <= 1'b0;
         DIV_NUM   <= '0;
         DIV_DEN   <= '0;
         RSP_VALID <= '0;
         RSP_ID    <= '0;
         RSP_COC   <= '0;
         RSP_RES   <= '0;
`ifdef DIV_ZERO_BYPASS_EN
         rsp_err_q <= 1'b0;
         bypass    <= 1'b0;
`endif
      end else begin
         GNT       <= '0;
         DIV_START <= 1'b0;
         RSP_VALID <= '0;
         case (state)
            S_IDLE, S_RESP: begin
               if (win_found) begin
                  GNT     <= onehot(win_idx);
                  DIV_NUM <= win_num;
                  DIV_DEN <= win_den;
                  RSP_ID  <= win_idx;
                  ptr     <= ptr_nxt;
`ifdef DIV_ZERO_BYPASS_EN
                  bypass  <= (win_den == '0);
`endif
                  state   <= S_LAUNCH;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_LAUNCH: begin
`ifdef DIV_ZERO_BYPASS_EN
               if (bypass) begin
                  RSP_COC   <= '1;
                  RSP_RES   <= DIV_NUM;
                  rsp_err_q <= 1'b1;
                  RSP_VALID <= onehot(RSP_ID);
                  state     <= S_RESP;
               end else begin
                  DIV_START <= 1'b1;
                  state     <= S_WAIT;
               end
`else
               DIV_START <= 1'b1;
               state     <= S_WAIT;
`endif
            end
            S_WAIT: begin
               // DONE seen while START is still out is left over from the previous operation.
               if (DIV_DONE && !DIV_START) begin
                  RSP_COC   <= DIV_COC;
                  RSP_RES   <= DIV_RES;
`ifdef DIV_ZERO_BYPASS_EN
                  rsp_err_q <= 1'b0;
`endif
                  RSP_VALID <= onehot(RSP_ID);
                  state     <= S_RESP;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_arbiter.sv
// tb/tb_divisor_arbiter.sv - directed bench for divisor_arbiter with a fixed-latency divider model
module tb_divisor_arbiter;
   localparam int SIZE = 32;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int L    = 3;

   logic                 CLK = 1'b0;
   logic                 RST_N;
   logic [NREQ-1:0]      REQ;
   logic [NREQ*SIZE-1:0] NUM_IN;
   logic [NREQ*SIZE-1:0] DEN_IN;
   logic [NREQ-1:0]      GNT;
   logic                 DIV_START;
   logic [SIZE-1:0]      DIV_NUM;
   logic [SIZE-1:0]      DIV_DEN;
   logic                 DIV_DONE;
   logic [SIZE-1:0]      DIV_COC;
   logic [SIZE-1:0]      DIV_RES;
   logic [NREQ-1:0]      RSP_VALID;
   logic [IDW-1:0]       RSP_ID;
   logic [SIZE-1:0]      RSP_COC;
   logic [SIZE-1:0]      RSP_RES;
   logic                 RSP_ERR;

   int checks = 0;
   int errors = 0;
   int cnt;

   divisor_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
      .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .NUM_IN(NUM_IN), .DEN_IN(DEN_IN),
      .GNT(GNT), .DIV_START(DIV_START), .DIV_NUM(DIV_NUM), .DIV_DEN(DIV_DEN),
      .DIV_DONE(DIV_DONE), .DIV_COC(DIV_COC), .DIV_RES(DIV_RES),
      .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_COC(RSP_COC),
      .RSP_RES(RSP_RES), .RSP_ERR(RSP_ERR)
   );

   always #5 CLK = ~CLK;

   // Divider model: DONE rises L cycles after the START cycle and stays high until the next START.
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DIV_DONE <= 1'b0;
         DIV_COC  <= '0;
         DIV_RES  <= '0;
         cnt      <= 0;
      end else if (DIV_START) begin
         DIV_DONE <= 1'b0;
         cnt      <= L - 1;
         if (DIV_DEN == 0) begin
            DIV_COC <= '1;
            DIV_RES <= DIV_NUM;
         end else begin
            DIV_COC <= DIV_NUM / DIV_DEN;
            DIV_RES <= DIV_NUM % DIV_DEN;
         end
      end else if (cnt == 1) begin
         DIV_DONE <= 1'b1;
         cnt      <= 0;
      end else if (cnt > 1) begin
         cnt <= cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic set_op(input int i, input logic [SIZE-1:0] n, input logic [SIZE-1:0] d);
      NUM_IN[i*SIZE +: SIZE] = n;
      DEN_IN[i*SIZE +: SIZE] = d;
   endtask

   int          fair_id  [5] = '{0, 1, 2, 3, 0};
   logic [31:0] fair_num [4] = '{32'd50, 32'd17, 32'd100, 32'd1000};
   logic [31:0] fair_coc [4] = '{32'd8, 32'd3, 32'd14, 32'd30};
   logic [31:0] fair_res [4] = '{32'd2, 32'd2, 32'd2, 32'd10};
   logic [31:0] fair_den [4] = '{32'd6, 32'd5, 32'd7, 32'd33};

   initial begin
      RST_N  = 1'b0;
      REQ    = '0;
      NUM_IN = '0;
      DEN_IN = '0;
      step(2);
      chk("rst_gnt", 64'(GNT), 64'h0);
      chk("rst_start", 64'(DIV_START), 64'h0);
      chk("rst_valid", 64'(RSP_VALID), 64'h0);
      chk("rst_divnum", 64'(DIV_NUM), 64'h0);
      chk("rst_rspid", 64'(RSP_ID), 64'h0);
      chk("rst_coc", 64'(RSP_COC), 64'h0);
      chk("rst_err", 64'(RSP_ERR), 64'h0);
      RST_N = 1'b1;
      step(1);

      // Fairness: all requesters held high
      for (int i = 0; i < 4; i++) set_op(i, fair_num[i], fair_den[i]);
      REQ = 4'b1111;
      step(1);
      for (int k = 0; k < 5; k++) begin
         int id;
         id = fair_id[k];
         chk($sformatf("fair_gnt%0d", k), 64'(GNT), 64'(4'b0001 << id));
         chk($sformatf("fair_num%0d", k), 64'(DIV_NUM), 64'(fair_num[id]));
         if (k == 4) REQ = 4'b0000;
         step(1);
         chk($sformatf("fair_start%0d", k), 64'(DIV_START), 64'h1);
         chk($sformatf("fair_gnt_quiet%0d", k), 64'(GNT), 64'h0);
         step(1);
         chk($sformatf("fair_noearly%0d", k), 64'(RSP_VALID), 64'h0);
         step(2);
         chk($sformatf("fair_gap%0d", k), 64'(GNT), 64'h0);
         step(1);
         chk($sformatf("fair_valid%0d", k), 64'(RSP_VALID), 64'(4'b0001 << id));
         chk($sformatf("fair_id%0d", k), 64'(RSP_ID), 64'(id));
         chk($sformatf("fair_coc%0d", k), 64'(RSP_COC), 64'(fair_coc[id]));
         chk($sformatf("fair_res%0d", k), 64'(RSP_RES), 64'(fair_res[id]));
         step(1);
      end
      chk("fair_idle", 64'(GNT), 64'h0);

      // Single request: 100/7 from requester 2 (ptr is now 1)
      set_op(2, 32'd100, 32'd7);
      REQ = 4'b0100;
      step(1);
      chk("single_gnt", 64'(GNT), 64'h4);
      chk("single_den", 64'(DIV_DEN), 64'd7);
      REQ = 4'b0000;
      step(1);
      chk("single_start", 64'(DIV_START), 64'h1);
      step(1);
      chk("single_start_pulse", 64'(DIV_START), 64'h0);
      step(3);
      chk("single_valid", 64'(RSP_VALID), 64'h4);
      chk("single_id", 64'(RSP_ID), 64'd2);
      chk("single_coc", 64'(RSP_COC), 64'd14);
      chk("single_res", 64'(RSP_RES), 64'd2);
      chk("single_err", 64'(RSP_ERR), 64'h0);
      step(1);
      chk("single_valid_pulse", 64'(RSP_VALID), 64'h0);
      chk("single_hold_coc", 64'(RSP_COC), 64'd14);

      // Late request: requester 1 raises REQ while requester 0 is in WAIT (ptr is 3)
      set_op(0, 32'd50, 32'd6);
      set_op(1, 32'd17, 32'd5);
      REQ = 4'b0001;
      step(1);
      chk("late_gnt0", 64'(GNT), 64'h1);
      REQ = 4'b0000;
      step(2);
      REQ = 4'b0010;
      step(1);
      chk("late_nognt_a", 64'(GNT), 64'h0);
      step(1);
      chk("late_nognt_b", 64'(GNT), 64'h0);
      step(1);
      chk("late_valid0", 64'(RSP_VALID), 64'h1);
      chk("late_nognt_c", 64'(GNT), 64'h0);
      chk("late_coc0", 64'(RSP_COC), 64'd8);
      step(1);
      chk("late_gnt1", 64'(GNT), 64'h2);
      REQ = 4'b0000;
      step(1);
      chk("late_start1_stale", 64'(RSP_VALID), 64'h0);
      step(4);
      chk("late_valid1", 64'(RSP_VALID), 64'h2);
      chk("late_coc1", 64'(RSP_COC), 64'd3);
      chk("late_res1", 64'(RSP_RES), 64'd2);
      step(1);

      // Reset while in WAIT (ptr is 2)
      set_op(2, 32'd100, 32'd7);
      REQ = 4'b0100;
      step(1);
      chk("rstw_gnt", 64'(GNT), 64'h4);
      REQ = 4'b0000;
      step(2);
      RST_N = 1'b0;
      #1;
      chk("rstw_divnum", 64'(DIV_NUM), 64'h0);
      chk("rstw_rspid", 64'(RSP_ID), 64'h0);
      chk("rstw_coc", 64'(RSP_COC), 64'h0);
      chk("rstw_ptr", 64'(dut.ptr), 64'h0);
      step(3);
      chk("rstw_novalid", 64'(RSP_VALID), 64'h0);
      RST_N = 1'b1;
      set_op(3, 32'd1000, 32'd33);
      REQ = 4'b1000;
      step(1);
      chk("rstw_gnt3", 64'(GNT), 64'h8);
      REQ = 4'b0000;
      step(3);
      chk("rstw_novalid2", 64'(RSP_VALID), 64'h0);
      step(2);
      chk("rstw_valid3", 64'(RSP_VALID), 64'h8);
      chk("rstw_coc3", 64'(RSP_COC), 64'd30);
      chk("rstw_res3", 64'(RSP_RES), 64'd10);
      step(1);

      // Zero divide 55/0 from requester 1 (ptr is 0)
      set_op(1, 32'd55, 32'd0);
      REQ = 4'b0010;
      step(1);
      chk("zero_gnt", 64'(GNT), 64'h2);
      REQ = 4'b0000;
      step(1);
`ifdef DIV_ZERO_BYPASS_EN
      chk("zero_nostart", 64'(DIV_START), 64'h0);
      chk("zero_valid", 64'(RSP_VALID), 64'h2);
      chk("zero_coc", 64'(RSP_COC), 64'hFFFF_FFFF);
      chk("zero_res", 64'(RSP_RES), 64'd55);
      chk("zero_err", 64'(RSP_ERR), 64'h1);
      step(1);
      chk("zero_valid_pulse", 64'(RSP_VALID), 64'h0);
`else
      chk("zero_start", 64'(DIV_START), 64'h1);
      chk("zero_novalid", 64'(RSP_VALID), 64'h0);
      step(4);
      chk("zero_valid", 64'(RSP_VALID), 64'h2);
      chk("zero_err", 64'(RSP_ERR), 64'h0);
      chk("zero_id", 64'(RSP_ID), 64'd1);
`endif
      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
